// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DECODE
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] code;
    } ps2_key_evt_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one raw PS/2 pad line.
module ps2_line_filter #(
    parameter int   FILTER_LEN = 8,
    parameter logic INIT       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_raw,
    output logic o_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    // The filtered value only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
            r_filt  <= INIT;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/ps2_keyb_rx.sv
// PS/2 device-to-host deframer: filters the pad lines, decodes 11-bit frames and
// folds E0/F0 prefixes into flags on a single qualified scan-code event.
module ps2_keyb_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    output logic          code_valid,
    output logic [7:0]    code,
    output logic          released,
    output logic          extended,
    output logic          frame_err,
    output logic [7:0]    err_cnt,
    output ps2_rx_state_t dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ps2_rx_state_t r_state;
    ps2_rx_state_t w_next;

    logic          w_clk_f;
    logic          w_data_f;
    logic          r_clk_d;
    logic          w_fall;
    logic          w_timeout;
    logic          w_start_err;
    logic          w_decode;
    logic          w_good;
    logic          w_byte_err;
    logic          w_err;

    logic [7:0]    r_shreg;
    logic [2:0]    r_bitcnt;
    logic          r_parity;
    logic          r_stop;
    logic [TW-1:0] r_to_cnt;
    logic          r_ext_pend;
    logic          r_rel_pend;
    ps2_key_evt_t  r_evt;
    logic          r_code_valid;
    logic          r_frame_err;
    logic [7:0]    r_err_cnt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .INIT(1'b1)) u_clk_filt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_raw  (ps2_clk_i),
        .o_filt (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .INIT(1'b1)) u_data_filt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_raw  (ps2_data_i),
        .o_filt (w_data_f)
    );

    assign w_fall     = r_clk_d & ~w_clk_f;
    // A falling edge in the same cycle as expiry keeps the frame alive.
    assign w_timeout  = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT));
    assign w_decode   = (r_state == DECODE);
    assign w_good     = (^r_shreg ^ r_parity) & r_stop;
    assign w_byte_err = w_decode & ~w_good;
    assign w_err      = w_byte_err | w_start_err | w_timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    if (!w_data_f) w_next = DATA;
                    else           w_start_err = 1'b1;
                end
            end
            DATA:    if (w_fall && r_bitcnt == 3'd7) w_next = PARITY;
            PARITY:  if (w_fall) w_next = STOP;
            STOP:    if (w_fall) w_next = DECODE;
            DECODE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_d      <= 1'b1;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_parity     <= 1'b0;
            r_stop       <= 1'b0;
            r_to_cnt     <= '0;
            r_ext_pend   <= 1'b0;
            r_rel_pend   <= 1'b0;
            r_evt        <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_clk_d      <= w_clk_f;
            r_code_valid <= 1'b0;
            r_frame_err  <= w_err;

            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

            if (r_state == IDLE || w_fall || w_timeout) r_to_cnt <= '0;
            else                                         r_to_cnt <= r_to_cnt + TW'(1);

            if (r_state == IDLE && w_fall && !w_data_f) r_bitcnt <= '0;
            if (r_state == DATA && w_fall) begin
                r_shreg  <= {w_data_f, r_shreg[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (r_state == PARITY && w_fall) r_parity <= w_data_f;
            if (r_state == STOP && w_fall)   r_stop   <= w_data_f;

            if (w_decode && w_good) begin
                if (r_shreg == PS2_PREFIX_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shreg == PS2_PREFIX_REL) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    r_evt        <= '{released: r_rel_pend, extended: r_ext_pend, code: r_shreg};
                    r_code_valid <= 1'b1;
                    r_ext_pend   <= 1'b0;
                    r_rel_pend   <= 1'b0;
                end
            end

            // A corrupted or abandoned frame must not leave a prefix hanging.
            if (w_byte_err || w_timeout) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end
            if (w_timeout) r_shreg <= '0;
        end
    end

    assign code_valid = r_code_valid;
    assign code       = r_evt.code;
    assign released   = r_evt.released;
    assign extended   = r_evt.extended;
    assign frame_err  = r_frame_err;
    assign err_cnt    = r_err_cnt;
    assign dbg_state  = r_state;

endmodule
